// File: rtl/pd_tx_frame.sv
// pd_tx_frame: pulse-distance serial transmitter, several samples per sync frame.
//
// Samples come in over a valid/ready handshake and are queued in a DEPTH-deep
// FIFO. A frame starts once SAMPLES samples are queued, or earlier on a flush
// pulse. Each frame is a sync burst and silence, then WIDTH bits for each
// sample, then a stop burst and a low guard gap. A bit is a BBD-cycle high
// burst followed by BSD0 (bit 0) or BSD1 (bit 1) cycles low.
//
// Optional build macro: PD_TX_PARITY_EN. When defined, one even-parity bit
// (XOR of every data bit in the frame) is sent after the last data bit,
// encoded like a data bit.
//
// Ports:
//   clk_in     system clock
//   rst_n_in   synchronous reset, active low
//   valid_in   sample valid
//   audio_in   sample data, WIDTH bits
//   ready_out  FIFO not full (combinational from the registered level)
//   flush_in   one-cycle pulse: start a short frame with what is queued
//   out        line signal
//   busy       frame in progress
//   level_out  FIFO occupancy
//
// Every duration parameter must be between 1 and 65535. DEPTH is a power of
// two, at least 2, and no smaller than SAMPLES.
module pd_tx_frame #(
  parameter int unsigned SBD       = 800,
  parameter int unsigned SSD       = 800,
  parameter int unsigned BBD       = 400,
  parameter int unsigned BSD0      = 200,
  parameter int unsigned BSD1      = 400,
  parameter int unsigned GAP       = 1600,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned SAMPLES   = 4,
  parameter int unsigned DEPTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     valid_in,
  input  logic [WIDTH-1:0]         audio_in,
  output logic                     ready_out,
  input  logic                     flush_in,
  output logic                     out,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int SW = $clog2(SAMPLES + 1);

  localparam logic [15:0] SBD_M1  = 16'(SBD - 1);
  localparam logic [15:0] SSD_M1  = 16'(SSD - 1);
  localparam logic [15:0] BBD_M1  = 16'(BBD - 1);
  localparam logic [15:0] BSD0_M1 = 16'(BSD0 - 1);
  localparam logic [15:0] BSD1_M1 = 16'(BSD1 - 1);
  localparam logic [15:0] GAP_M1  = 16'(GAP - 1);

  localparam logic [LW-1:0] DEPTH_L   = LW'(DEPTH);
  localparam logic [LW-1:0] SAMPLES_L = LW'(SAMPLES);
  localparam logic [BW-1:0] LAST_BIT  = BW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE, SYNC_H, SYNC_L, BIT_H, BIT_L, STOP_H, GUARD
  } state_e;

  // ---------------------------------------------------------------- FIFO
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             push, pop;
  logic [WIDTH-1:0] head;

  assign ready_out = (level_q < DEPTH_L);
  assign push      = valid_in && ready_out;
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_n_in && push) mem_q[wr_ptr_q] <= audio_in;
  end

  // ---------------------------------------------------------------- FSM
  state_e           state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             bit_q, bit_d;
  logic [BW-1:0]    bit_idx_q, bit_idx_d;
  logic [SW-1:0]    samp_idx_q, samp_idx_d;
  logic [SW-1:0]    frame_len_q, frame_len_d;
`ifdef PD_TX_PARITY_EN
  logic             par_q, par_d;
  logic             par_phase_q, par_phase_d;
`endif

  // Bit-advance requests raised by the state case and resolved below it:
  // load_req takes the next bit from the FIFO head, next_req from the
  // shift register.
  logic             load_req, next_req;
  logic [WIDTH-1:0] src;
  logic             src_bit;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 16'd1;
    out_d       = out_q;
    busy_d      = busy_q;
    shreg_d     = shreg_q;
    bit_d       = bit_q;
    bit_idx_d   = bit_idx_q;
    samp_idx_d  = samp_idx_q;
    frame_len_d = frame_len_q;
    pop         = 1'b0;
    load_req    = 1'b0;
    next_req    = 1'b0;
`ifdef PD_TX_PARITY_EN
    par_d       = par_q;
    par_phase_d = par_phase_q;
`endif

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (level_q >= SAMPLES_L || (flush_in && level_q != '0)) begin
          state_d     = SYNC_H;
          out_d       = 1'b1;
          busy_d      = 1'b1;
          frame_len_d = (level_q >= SAMPLES_L) ? SW'(SAMPLES) : SW'(level_q);
          samp_idx_d  = '0;
`ifdef PD_TX_PARITY_EN
          par_d       = 1'b0;
          par_phase_d = 1'b0;
`endif
        end
      end
      SYNC_H: begin
        if (cnt_q == SBD_M1) begin
          cnt_d   = '0;
          out_d   = 1'b0;
          state_d = SYNC_L;
        end
      end
      SYNC_L: begin
        if (cnt_q == SSD_M1) begin
          cnt_d    = '0;
          load_req = 1'b1;
        end
      end
      BIT_H: begin
        if (cnt_q == BBD_M1) begin
          cnt_d   = '0;
          out_d   = 1'b0;
          state_d = BIT_L;
        end
      end
      BIT_L: begin
        if (cnt_q == (bit_q ? BSD1_M1 : BSD0_M1)) begin
          cnt_d = '0;
`ifdef PD_TX_PARITY_EN
          if (par_phase_q) begin
            state_d = STOP_H;
            out_d   = 1'b1;
          end else
`endif
          if (bit_idx_q != LAST_BIT) begin
            next_req = 1'b1;
          end else if (samp_idx_q != frame_len_q) begin
            load_req = 1'b1;
          end else begin
`ifdef PD_TX_PARITY_EN
            // Parity already holds every data bit: each bit is folded in
            // as it is selected at its burst entry.
            par_phase_d = 1'b1;
            bit_d       = par_q;
            state_d     = BIT_H;
            out_d       = 1'b1;
`else
            state_d = STOP_H;
            out_d   = 1'b1;
`endif
          end
        end
      end
      STOP_H: begin
        if (cnt_q == BBD_M1) begin
          cnt_d   = '0;
          out_d   = 1'b0;
          state_d = GUARD;
        end
      end
      GUARD: begin
        if (cnt_q == GAP_M1) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        out_d   = 1'b0;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase

    // Select the first remaining bit of src and shift it out of the register.
    src     = load_req ? head : shreg_q;
    src_bit = MSB_FIRST ? src[WIDTH-1] : src[0];
    if (load_req || next_req) begin
      bit_d     = src_bit;
      shreg_d   = MSB_FIRST ? (src << 1) : (src >> 1);
      state_d   = BIT_H;
      out_d     = 1'b1;
      bit_idx_d = load_req ? '0 : bit_idx_q + BW'(1);
`ifdef PD_TX_PARITY_EN
      par_d     = par_q ^ src_bit;
`endif
    end
    if (load_req) begin
      pop        = 1'b1;
      samp_idx_d = samp_idx_q + SW'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_q       <= 1'b0;
      busy_q      <= 1'b0;
      shreg_q     <= '0;
      bit_q       <= 1'b0;
      bit_idx_q   <= '0;
      samp_idx_q  <= '0;
      frame_len_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
`ifdef PD_TX_PARITY_EN
      par_q       <= 1'b0;
      par_phase_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      busy_q      <= busy_d;
      shreg_q     <= shreg_d;
      bit_q       <= bit_d;
      bit_idx_q   <= bit_idx_d;
      samp_idx_q  <= samp_idx_d;
      frame_len_q <= frame_len_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
`ifdef PD_TX_PARITY_EN
      par_q       <= par_d;
      par_phase_q <= par_phase_d;
`endif
    end
  end

  assign out       = out_q;
  assign busy      = busy_q;
  assign level_out = level_q;

endmodule

// File: tb/tb_pd_tx_frame.sv
// Bench for pd_tx_frame: one MSB-first and one LSB-first instance with short
// timings. Frames are captured as alternating high/low run lengths while busy
// and compared with runs built from hand-written bit sequences.
module tb_pd_tx_frame;
  localparam int SBD = 8, SSD = 8, BBD = 4, BSD0 = 2, BSD1 = 4, GAP = 10;
  localparam int W = 4, S = 2, D = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         valid_a, valid_b, flush_a, flush_b;
  logic [W-1:0] din_a, din_b;
  logic         ready_a, ready_b, out_a, out_b, busy_a, busy_b;
  logic [2:0]   lvl_a, lvl_b;

  pd_tx_frame #(.SBD(SBD), .SSD(SSD), .BBD(BBD), .BSD0(BSD0), .BSD1(BSD1),
    .GAP(GAP), .WIDTH(W), .SAMPLES(S), .DEPTH(D), .MSB_FIRST(1'b1)) u_msb (
    .clk_in(clk), .rst_n_in(rst_n), .valid_in(valid_a), .audio_in(din_a),
    .ready_out(ready_a), .flush_in(flush_a), .out(out_a), .busy(busy_a),
    .level_out(lvl_a));

  pd_tx_frame #(.SBD(SBD), .SSD(SSD), .BBD(BBD), .BSD0(BSD0), .BSD1(BSD1),
    .GAP(GAP), .WIDTH(W), .SAMPLES(S), .DEPTH(D), .MSB_FIRST(1'b0)) u_lsb (
    .clk_in(clk), .rst_n_in(rst_n), .valid_in(valid_b), .audio_in(din_b),
    .ready_out(ready_b), .flush_in(flush_b), .out(out_b), .busy(busy_b),
    .level_out(lvl_b));

  int errors = 0, checks = 0;
  int cap_runs[$];
  int cap_total;
  bit cap_to;

  typedef struct {
    string      name;
    int         n;
    logic [3:0] d0;
    logic [3:0] d1;
    logic [7:0] bits;   // transmission order: bit [n*4-1] first
    int         total;  // busy cycles without parity
  } vec_t;
  vec_t vt[8];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic out_of(input int w);
    return (w == 0) ? out_a : out_b;
  endfunction
  function automatic logic busy_of(input int w);
    return (w == 0) ? busy_a : busy_b;
  endfunction

  task automatic push(input int w, input logic [3:0] d);
    if (w == 0) begin valid_a = 1'b1; din_a = d; end
    else begin valid_b = 1'b1; din_b = d; end
    @(posedge clk); #1;
    valid_a = 1'b0;
    valid_b = 1'b0;
  endtask

  task automatic pulse_flush(input int w);
    if (w == 0) flush_a = 1'b1; else flush_b = 1'b1;
    @(posedge clk); #1;
    flush_a = 1'b0;
    flush_b = 1'b0;
  endtask

  // Waits for busy, then records run lengths until busy drops. Returns on
  // the falling-edge sample where busy is first seen low.
  task automatic capture(input int w);
    int t, len;
    logic cur, prev;
    cap_runs.delete();
    cap_total = 0;
    t = 0;
    do begin @(negedge clk); t++; end while (!busy_of(w) && t < 200);
    if (!busy_of(w)) begin cap_to = 1'b1; return; end
    cap_to = 1'b0;
    prev = out_of(w);
    len = 0;
    while (busy_of(w) && cap_total < 5000) begin
      cur = out_of(w);
      if (cur != prev) begin cap_runs.push_back(len); len = 0; prev = cur; end
      len++;
      cap_total++;
      @(negedge clk);
    end
    cap_runs.push_back(len);
  endtask

  task automatic cmp_frame(input string nm, input logic [7:0] bits,
                           input int nbits, input int total);
    int exp[$];
    int tot;
    exp.push_back(SBD);
    exp.push_back(SSD);
    for (int k = nbits - 1; k >= 0; k--) begin
      exp.push_back(BBD);
      exp.push_back(bits[k] ? BSD1 : BSD0);
    end
    tot = total;
`ifdef PD_TX_PARITY_EN
    begin
      logic p;
      p = ^bits;
      exp.push_back(BBD);
      exp.push_back(p ? BSD1 : BSD0);
      tot += BBD + (p ? BSD1 : BSD0);
    end
`endif
    exp.push_back(BBD);
    exp.push_back(GAP);
    chk({nm, " timeout"}, int'(cap_to), 0);
    chk({nm, " run_count"}, cap_runs.size(), exp.size());
    if (cap_runs.size() == exp.size())
      for (int k = 0; k < exp.size(); k++)
        chk($sformatf("%s run%0d", nm, k), cap_runs[k], exp[k]);
    chk({nm, " total"}, cap_total, tot);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, nb, no;

    vt[0] = '{"msb_a3",  2, 4'hA, 4'h3, 8'b1010_0011, 86};
    vt[1] = '{"msb_71",  2, 4'h7, 4'h1, 8'b0111_0001, 86};
    vt[2] = '{"msb_70",  2, 4'h7, 4'h0, 8'b0111_0000, 84};
    vt[3] = '{"msb_5c",  2, 4'h5, 4'hC, 8'b0101_1100, 86};
    vt[4] = '{"msb_ff",  2, 4'hF, 4'hF, 8'b1111_1111, 94};
    vt[5] = '{"msb_00",  2, 4'h0, 4'h0, 8'b0000_0000, 78};
    vt[6] = '{"flush_f", 1, 4'hF, 4'h0, 8'b0000_1111, 62};
    vt[7] = '{"flush_2", 1, 4'h2, 4'h0, 8'b0000_0010, 56};

    rst_n = 1'b0;
    valid_a = 1'b0; valid_b = 1'b0; flush_a = 1'b0; flush_b = 1'b0;
    din_a = '0; din_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset out", out_a, 0);
    chk("reset busy", busy_a, 0);
    chk("reset level", lvl_a, 0);
    chk("reset ready", ready_a, 1);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      push(0, vt[i].d0);
      if (vt[i].n == 2) push(0, vt[i].d1);
      else pulse_flush(0);
      capture(0);
      cmp_frame(vt[i].name, vt[i].bits, vt[i].n * 4, vt[i].total);
      @(posedge clk); #1;
      chk({vt[i].name, " level_after"}, lvl_a, 0);
    end

    // LSB-first: 1 then 0 -> first bit one, next seven zero.
    @(posedge clk); #1;
    push(1, 4'h1);
    push(1, 4'h0);
    capture(1);
    cmp_frame("lsb_10", 8'b1000_0000, 8, 80);

    // Flush with an empty FIFO does nothing.
    @(posedge clk); #1;
    pulse_flush(0);
    nb = 0;
    repeat (10) begin @(negedge clk); if (busy_a) nb++; end
    chk("flush_empty busy", nb, 0);

    // Backpressure: ten offered samples, four taken, two frames in order.
    acc = 0;
    @(posedge clk); #1;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          valid_a = 1'b1;
          din_a = 4'(i);
          @(negedge clk);
          if (ready_a) acc++;
          @(posedge clk); #1;
        end
        valid_a = 1'b0;
        chk("bp accepts", acc, 4);
        chk("bp level", lvl_a, 4);
        chk("bp ready", ready_a, 0);
      end
      begin
        capture(0);
        cmp_frame("bp_f1", 8'h01, 8, 80);
        capture(0);
        cmp_frame("bp_f2", 8'h23, 8, 84);
      end
    join
    @(posedge clk); #1;
    chk("bp level_end", lvl_a, 0);

    // Flush while busy is ignored; mid-frame sample stays queued.
    push(0, 4'hF);
    push(0, 4'hF);
    fork
      capture(0);
      begin
        repeat (20) @(posedge clk);
        #1;
        push(0, 4'h5);
        pulse_flush(0);
      end
    join
    cmp_frame("busy_ff", 8'hFF, 8, 94);
    nb = 0;
    repeat (12) begin @(negedge clk); if (busy_a) nb++; end
    chk("busy_flush ignored", nb, 0);
    chk("busy_flush level", lvl_a, 1);
    @(posedge clk); #1;
    pulse_flush(0);
    capture(0);
    cmp_frame("drain_5", 8'h05, 4, 58);
    @(posedge clk); #1;
    chk("drain level", lvl_a, 0);

    // Reset in the first bit's low phase.
    push(0, 4'hA);
    push(0, 4'h3);
    nb = 0;
    do begin @(negedge clk); nb++; end while (!busy_a && nb < 50);
    chk("rst launch", busy_a, 1);
    repeat (SBD + SSD + BBD + 1) @(negedge clk);
    chk("rst pre out", out_a, 0);
    chk("rst pre level", lvl_a, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst out", out_a, 0);
    chk("rst busy", busy_a, 0);
    chk("rst level", lvl_a, 0);
    chk("rst ready", ready_a, 1);
    rst_n = 1'b1;
    nb = 0; no = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy_a) nb++;
      if (out_a) no++;
    end
    chk("post_rst busy", nb, 0);
    chk("post_rst out", no, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
